// File: rtl/uart_gpio_pkg.sv
// ============================================================================
// Module      : uart_gpio_pkg
// Description : Shared FSM state encodings, data width and parity helper for
//               uart_gpio_rx. The optional parity feature is enabled by
//               defining UART_GPIO_RX_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_gpio_pkg;

  localparam int unsigned c_data_w = 8;
  localparam int unsigned c_bit_idx_w = $clog2(c_data_w);

`ifdef UART_GPIO_RX_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  // Even parity: the transmitted parity bit makes the total count of ones even.
  function automatic logic even_parity(input logic [c_data_w-1:0] d);
    return ^d;
  endfunction
`else
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd4
  } state_t;
`endif

endpackage

`default_nettype wire

// File: rtl/uart_gpio_rx_sync2.sv
// ============================================================================
// Module      : sync2
// Description : Two-flop synchronizer for an asynchronous single-bit input;
//               flops reset to RESET_VAL so an idle-high line stays quiet.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync2
  import uart_gpio_pkg::*;
#(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule

`default_nettype wire

// File: rtl/uart_gpio_rx.sv
// ============================================================================
// Module      : uart_gpio_rx
// Description : UART receiver (8 data bits, LSB first) that drives a GPIO
//               register write port. Define UART_GPIO_RX_PARITY_EN to add
//               an even-parity bit between the data and the stop bit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_gpio_rx
  import uart_gpio_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 104
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                rx,
  output logic                we,
  output logic [c_data_w-1:0] wdata,
  output logic                frame_err,
  output logic                busy
);

  localparam int unsigned c_cnt_w = $clog2(CLKS_PER_BIT);
  localparam logic [c_cnt_w-1:0] c_bit_last  = c_cnt_w'(CLKS_PER_BIT - 1);
  localparam logic [c_cnt_w-1:0] c_half_last = c_cnt_w'(CLKS_PER_BIT / 2 - 1);
  localparam logic [c_bit_idx_w-1:0] c_bit_idx_last = c_bit_idx_w'(c_data_w - 1);

  logic                   w_rx_s;
  logic                   r_rx_prev;
  logic                   w_fall;
  logic                   w_bit_done;
  logic                   w_par_good;

  state_t                 r_state,   w_state_nxt;
  logic [c_cnt_w-1:0]     r_cnt,     w_cnt_nxt;
  logic [c_bit_idx_w-1:0] r_bit_idx, w_bit_idx_nxt;
  logic [c_data_w-1:0]    r_shift,   w_shift_nxt;
  logic [c_data_w-1:0]    r_wdata,   w_wdata_nxt;
  logic                   r_we,      w_we_nxt;
  logic                   r_ferr,    w_ferr_nxt;

  sync2 #(
    .RESET_VAL(1'b1)
  ) u_sync2 (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (rx),
    .q    (w_rx_s)
  );

  // Only a genuine 1->0 transition starts a frame; a line stuck low never retriggers.
  assign w_fall     = r_rx_prev & ~w_rx_s;
  assign w_bit_done = (r_cnt == c_bit_last);

`ifdef UART_GPIO_RX_PARITY_EN
  logic r_par_ok, w_par_ok_nxt;
  assign w_par_good = r_par_ok;
`else
  assign w_par_good = 1'b1;
`endif

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_bit_idx_nxt = r_bit_idx;
    w_shift_nxt   = r_shift;
    w_wdata_nxt   = r_wdata;
    w_we_nxt      = 1'b0;
    w_ferr_nxt    = 1'b0;
`ifdef UART_GPIO_RX_PARITY_EN
    w_par_ok_nxt  = r_par_ok;
`endif
    unique case (r_state)
      ST_IDLE: begin
        w_cnt_nxt = '0;
        if (w_fall) begin
          w_state_nxt = ST_START;
        end
      end
      ST_START: begin
        if (r_cnt == c_half_last) begin
          w_cnt_nxt = '0;
          if (!w_rx_s) begin
            w_state_nxt   = ST_DATA;
            w_bit_idx_nxt = '0;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      ST_DATA: begin
        if (w_bit_done) begin
          w_cnt_nxt     = '0;
          w_shift_nxt   = {w_rx_s, r_shift[c_data_w-1:1]};
          w_bit_idx_nxt = r_bit_idx + 1'b1;
          if (r_bit_idx == c_bit_idx_last) begin
`ifdef UART_GPIO_RX_PARITY_EN
            w_state_nxt = ST_PARITY;
`else
            w_state_nxt = ST_STOP;
`endif
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
`ifdef UART_GPIO_RX_PARITY_EN
      ST_PARITY: begin
        if (w_bit_done) begin
          w_cnt_nxt    = '0;
          w_par_ok_nxt = (even_parity(r_shift) == w_rx_s);
          w_state_nxt  = ST_STOP;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
`endif
      ST_STOP: begin
        if (w_bit_done) begin
          w_cnt_nxt   = '0;
          w_state_nxt = ST_IDLE;
          if (w_rx_s && w_par_good) begin
            w_we_nxt    = 1'b1;
            w_wdata_nxt = r_shift;
          end else begin
            w_ferr_nxt = 1'b1;
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_wdata   <= '0;
      r_we      <= 1'b0;
      r_ferr    <= 1'b0;
      r_rx_prev <= 1'b1;
`ifdef UART_GPIO_RX_PARITY_EN
      r_par_ok  <= 1'b0;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_bit_idx <= w_bit_idx_nxt;
      r_shift   <= w_shift_nxt;
      r_wdata   <= w_wdata_nxt;
      r_we      <= w_we_nxt;
      r_ferr    <= w_ferr_nxt;
      r_rx_prev <= w_rx_s;
`ifdef UART_GPIO_RX_PARITY_EN
      r_par_ok  <= w_par_ok_nxt;
`endif
    end
  end

  assign we        = r_we;
  assign wdata     = r_wdata;
  assign frame_err = r_ferr;
  assign busy      = (r_state != ST_IDLE);

endmodule

`default_nettype wire

// File: doc/uart_gpio_rx.md
UART_GPIO_RX -- requirements
Module: uart_gpio_rx

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 104, meaning clk cycles per UART bit (minimum 4).
REQ-002 The block SHALL have port clk  input  1  system clock, all logic on posedge.
REQ-003 The block SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 The block SHALL have port rx  input  1  asynchronous serial line, idle high.
REQ-005 The block SHALL have port we  output  1  write strobe to the GPIO register, one-cycle pulse.
REQ-006 The block SHALL have port wdata  output  8  last correctly received byte, valid whenever we=1 and held afterwards.
REQ-007 The block SHALL have port frame_err  output  1  one-cycle pulse on a rejected frame.
REQ-008 The block SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-009 rx SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value (2-cycle input latency).
REQ-010 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP.
REQ-011 IDLE->START SHALL occur only on a synchronized falling edge of rx (previous 1, current 0); a line held low never retriggers.
REQ-012 START SHALL count CLKS_PER_BIT/2 cycles, then resample: 0 -> DATA with bit counter cleared; 1 -> IDLE silently (glitch, no frame_err).
REQ-013 DATA SHALL sample rx every CLKS_PER_BIT cycles, shifting LSB first, 8 bits; after the 8th bit go to PARITY if enabled, else STOP.
REQ-014 STOP SHALL sample rx after CLKS_PER_BIT cycles; valid frame = stop bit 1 and (if enabled) parity OK.
REQ-015 On a valid frame, wdata SHALL load the shifted byte and we SHALL pulse high for exactly one cycle, in the cycle after the stop sample; FSM returns to IDLE in that same cycle.
REQ-016 On an invalid frame, frame_err SHALL pulse one cycle, we SHALL stay low, wdata SHALL keep its previous value; FSM returns to IDLE.
REQ-017 we and frame_err SHALL never be high in the same cycle.
REQ-018 The baud counter SHALL be $clog2(CLKS_PER_BIT) bits, reload to 0 on every sample point, never wrap mid-bit.
REQ-019 A new falling edge arriving during the cycle we pulses SHALL be detected in IDLE on the next cycle (back-to-back frames, stop bit of 1 bit length, supported).

Reset
REQ-020 On rst_n low, state=IDLE, counters=0, we=0, frame_err=0, busy=0, wdata=8'h00, synchronizer flops=1 (idle line), asynchronously.
REQ-021 Reset asserted mid-frame SHALL abort the frame with no we and no frame_err; after release, reception restarts only on a new falling edge.

Configuration
REQ-022 Macro UART_GPIO_RX_PARITY_EN defined: PARITY state present, one even-parity bit sampled CLKS_PER_BIT after the 8th data bit; mismatch -> invalid frame (REQ-016).
REQ-023 Macro absent: no PARITY state, no parity logic, frame = start + 8 data + stop.

Structure
REQ-024 FSM state encodings and the data width constant (8) SHALL live in shared package uart_gpio_pkg.
REQ-025 The 2-flop synchronizer SHALL be a separate sub-module sync2; baud counting and FSM stay in uart_gpio_rx.
REQ-026 Outputs we/wdata SHALL connect directly to the GPIO register we/wdata inputs with no glue logic.

Verification (CLKS_PER_BIT=8)
REQ-027 Send 0xA5, valid stop -> single we pulse, wdata=0xA5, frame_err=0, busy low afterwards.
REQ-028 Send 0x3C then 0xC3 back-to-back -> two we pulses, wdata=0x3C then 0xC3, no missed frame.
REQ-029 rx low for 2 cycles then high -> no we, no frame_err, busy returns 0 within CLKS_PER_BIT/2+3 cycles.
REQ-030 Send 0x5A with stop bit 0 -> frame_err pulse, no we, wdata keeps prior value (0xA5).
REQ-031 Assert rst_n after 4th data bit of 0xFF -> outputs at reset values, no we; following 0x11 frame received correctly.
REQ-032 With UART_GPIO_RX_PARITY_EN: 0x07 with parity 1 -> we, wdata=0x07; with parity 0 -> frame_err, no we.
